// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and widths for the fetch-PC redirect controller.
package pc_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int RETRY_W = 3;
  localparam int FCNT_W  = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REPLAY = 2'd2,
    ST_FATAL  = 2'd3
  } state_e;

  // Winning request source in RUN; only consumed by assertions.
  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_FAULT  = 3'd1,
    SRC_TRAP   = 3'd2,
    SRC_BRANCH = 3'd3,
    SRC_STALL  = 3'd4
  } redir_src_e;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_checkpoint.sv
// Replay checkpoint: address following the last retired instruction.
module pc_checkpoint
  import pc_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_commit_pc,
  output logic [ADDR_W-1:0] o_checkpoint
);

  logic [ADDR_W-1:0] r_ckpt;

  // Wraps modulo 2^32 by construction of the adder width.
  always_ff @(posedge clk) begin
    if (reset)       r_ckpt <= RESET_ADDR;
    else if (i_load) r_ckpt <= i_commit_pc + ADDR_W'(4);
  end

  assign o_checkpoint = r_ckpt;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: merges stall/branch/trap/fault into hold/redirect and runs fault recovery.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned branch targets into a trap redirect.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR   = 32'h0000_0000,
  parameter int                FLUSH_CYCLES = 2,
  parameter int                MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_stall_req,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  input  logic               i_trap_req,
  input  logic [ADDR_W-1:0]  i_trap_vector,
  input  logic               i_fault_detect,
  input  logic               i_commit_valid,
  input  logic [ADDR_W-1:0]  i_commit_pc,
  output logic               o_pc_hold,
  output logic               o_pc_redirect,
  output logic [ADDR_W-1:0]  o_redirect_addr,
  output logic               o_flush_if_id,
  output logic               o_flush_id_ex,
  output logic               o_recovery_busy,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic               o_fatal,
  output logic               o_misalign_flag
);

  state_e             r_state, w_state_nxt;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt;
  logic [FCNT_W-1:0]  r_fcnt,  w_fcnt_nxt;
  logic [ADDR_W-1:0]  w_ckpt;
  redir_src_e         w_src;
  logic               w_misalign;

  pc_checkpoint #(.RESET_ADDR(RESET_ADDR)) u_ckpt (
    .clk          (clk),
    .reset        (reset),
    .i_load       (i_commit_valid && (r_state != ST_FATAL)),
    .i_commit_pc  (i_commit_pc),
    .o_checkpoint (w_ckpt)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_retry_nxt     = r_retry;
    w_fcnt_nxt      = r_fcnt;
    w_src           = SRC_NONE;
    w_misalign      = 1'b0;
    o_pc_hold       = 1'b0;
    o_pc_redirect   = 1'b0;
    o_redirect_addr = '0;
    o_flush_if_id   = 1'b0;
    o_flush_id_ex   = 1'b0;
    o_recovery_busy = 1'b0;
    o_fatal         = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (i_fault_detect) begin
          w_src         = SRC_FAULT;
          o_pc_hold     = 1'b1;
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
          // A same-cycle commit does not clear the count: the fault wins.
          if (r_retry < RETRY_W'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_fcnt_nxt  = FCNT_W'(FLUSH_CYCLES - 1);
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_FATAL;
          end
        end else begin
          if (i_commit_valid) w_retry_nxt = '0;
          if (i_trap_req) begin
            w_src           = SRC_TRAP;
            o_pc_redirect   = 1'b1;
            o_redirect_addr = i_trap_vector;
            o_flush_if_id   = 1'b1;
            o_flush_id_ex   = 1'b1;
          end else if (i_branch_taken) begin
            w_src           = SRC_BRANCH;
            o_pc_redirect   = 1'b1;
            o_flush_if_id   = 1'b1;
            o_flush_id_ex   = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if (is_misaligned(i_branch_target)) begin
              o_redirect_addr = i_trap_vector;
              w_misalign      = 1'b1;
            end else begin
              o_redirect_addr = i_branch_target;
            end
`else
            o_redirect_addr = i_branch_target;
`endif
          end else if (i_stall_req) begin
            w_src     = SRC_STALL;
            o_pc_hold = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        o_pc_hold       = 1'b1;
        o_flush_if_id   = 1'b1;
        o_flush_id_ex   = 1'b1;
        o_recovery_busy = 1'b1;
        if (r_fcnt == '0) w_state_nxt = ST_REPLAY;
        else              w_fcnt_nxt  = r_fcnt - FCNT_W'(1);
      end
      ST_REPLAY: begin
        o_pc_redirect   = 1'b1;
        o_redirect_addr = w_ckpt;
        o_flush_if_id   = 1'b1;
        o_recovery_busy = 1'b1;
        w_state_nxt     = ST_RUN;
      end
      ST_FATAL: begin
        o_pc_hold     = 1'b1;
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        o_fatal       = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_retry <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  assign o_retry_cnt     = r_retry;
  assign o_misalign_flag = w_misalign;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(o_pc_hold && o_pc_redirect));
      assert (!((w_src == SRC_STALL || w_src == SRC_FAULT) && o_pc_redirect));
      assert (!(w_src == SRC_TRAP && o_redirect_addr != i_trap_vector));
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: vector table for RUN priority plus recovery sequences.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br, trap, fault, cmt;
  logic [31:0] tgt, tvec, cpc;
  logic        hold, redir, fif, fie, busy, fat, mis;
  logic [31:0] addr;
  logic [2:0]  rc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk(clk), .reset(reset),
    .i_stall_req(stall), .i_branch_taken(br), .i_branch_target(tgt),
    .i_trap_req(trap), .i_trap_vector(tvec), .i_fault_detect(fault),
    .i_commit_valid(cmt), .i_commit_pc(cpc),
    .o_pc_hold(hold), .o_pc_redirect(redir), .o_redirect_addr(addr),
    .o_flush_if_id(fif), .o_flush_id_ex(fie), .o_recovery_busy(busy),
    .o_retry_cnt(rc), .o_fatal(fat), .o_misalign_flag(mis)
  );

  typedef struct {
    logic        stall, br;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] tvec;
    logic        cmt;
    logic [31:0] cpc;
    logic        hold, redir;
    logic [31:0] addr;
    logic        fif, fie, mis;
  } vec_t;

  vec_t vecs[9];

  task automatic idle_in();
    stall = 0; br = 0; tgt = '0; trap = 0; tvec = '0; fault = 0; cmt = 0; cpc = '0;
  endtask

  // Flags packed as {hold,redir,fif,fie,busy,fatal,mis,retry[2:0]} then address.
  task automatic chk(input string nm, input logic h, input logic r, input logic [31:0] a,
                     input logic f1, input logic f2, input logic b, input logic ft,
                     input logic m, input logic [2:0] c);
    logic [41:0] got, exp;
    got = {hold, redir, fif, fie, busy, fat, mis, rc, addr};
    exp = {h, r, f1, f2, b, ft, m, c, a};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got flags=%b addr=%h, expected flags=%b addr=%h",
               nm, got[41:32], got[31:0], exp[41:32], exp[31:0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); idle_in(); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  // Fault at T, FLUSH T+1..T+2, REPLAY T+3 (fault there is ignored), RUN T+4.
  task automatic fault_seq(input string nm, input logic [31:0] ck, input logic [2:0] r0,
                           input logic with_tb, input logic cmt_t, input logic [31:0] cpc_t,
                           input logic cmt_f, input logic [31:0] cpc_f);
    logic [2:0] r1;
    r1 = r0 + 3'd1;
    @(negedge clk); idle_in(); fault = 1;
    if (with_tb) begin trap = 1; tvec = 32'h200; br = 1; tgt = 32'h100; end
    cmt = cmt_t; cpc = cpc_t;
    #2 chk({nm, " T"}, 1, 0, 0, 1, 1, 0, 0, 0, r0);
    @(negedge clk); idle_in(); cmt = cmt_f; cpc = cpc_f; trap = 1; tvec = 32'h300;
    #2 chk({nm, " T+1"}, 1, 0, 0, 1, 1, 1, 0, 0, r1);
    @(negedge clk); idle_in(); br = 1; tgt = 32'h500;
    #2 chk({nm, " T+2"}, 1, 0, 0, 1, 1, 1, 0, 0, r1);
    @(negedge clk); idle_in(); fault = 1;
    #2 chk({nm, " T+3"}, 0, 1, ck, 1, 0, 1, 0, 0, r1);
    @(negedge clk); idle_in();
    #2 chk({nm, " T+4"}, 0, 0, 0, 0, 0, 0, 0, 0, r1);
  endtask

  initial begin
    logic exp_mis;
    logic [31:0] exp_mis_addr;
`ifdef PC_ALIGN_CHECK_EN
    exp_mis = 1; exp_mis_addr = 32'h200;
`else
    exp_mis = 0; exp_mis_addr = 32'h102;
`endif
    //        stall br tgt          trap tvec         cmt cpc        hold redir addr        fif fie mis
    vecs[0] = '{0, 0, 32'h0,       0,   32'h0,       0,  32'h0,     0,   0,    32'h0,       0,  0,  0};
    vecs[1] = '{1, 0, 32'h0,       0,   32'h0,       0,  32'h0,     1,   0,    32'h0,       0,  0,  0};
    vecs[2] = '{1, 1, 32'h100,     0,   32'h0,       0,  32'h0,     0,   1,    32'h100,     1,  1,  0};
    vecs[3] = '{0, 1, 32'h100,     1,   32'h200,     0,  32'h0,     0,   1,    32'h200,     1,  1,  0};
    vecs[4] = '{1, 0, 32'h0,       1,   32'h300,     0,  32'h0,     0,   1,    32'h300,     1,  1,  0};
    vecs[5] = '{0, 1, 32'h104,     0,   32'h200,     0,  32'h0,     0,   1,    32'h104,     1,  1,  0};
    vecs[6] = '{0, 1, 32'h102,     0,   32'h200,     0,  32'h0,     0,   1,    exp_mis_addr, 1, 1, exp_mis};
    vecs[7] = '{0, 0, 32'h0,       0,   32'h0,       1,  32'h40,    0,   0,    32'h0,       0,  0,  0};
    vecs[8] = '{1, 0, 32'h0,       0,   32'h0,       1,  32'h40,    1,   0,    32'h0,       0,  0,  0};

    idle_in(); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_in();
      #2 chk($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    end

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      stall = vecs[i].stall; br = vecs[i].br; tgt = vecs[i].tgt; trap = vecs[i].trap;
      tvec = vecs[i].tvec; cmt = vecs[i].cmt; cpc = vecs[i].cpc; fault = 0;
      #2 chk($sformatf("vec%0d", i), vecs[i].hold, vecs[i].redir, vecs[i].addr,
             vecs[i].fif, vecs[i].fie, 0, 0, vecs[i].mis, 3'd0);
    end
    @(negedge clk); idle_in();
    #2 chk("misalign pulse ends", 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);

    // Four faults with no commit between: three replays to 0x44, fourth goes fatal.
    fault_seq("fault1", 32'h44, 3'd0, 1, 0, 0, 0, 0);
    fault_seq("fault2", 32'h44, 3'd1, 0, 0, 0, 0, 0);
    fault_seq("fault3", 32'h44, 3'd2, 0, 0, 0, 0, 0);
    @(negedge clk); idle_in(); fault = 1;
    #2 chk("fault4 T", 1, 0, 0, 1, 1, 0, 0, 0, 3'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_in(); br = 1; tgt = 32'h100; cmt = 1; cpc = 32'h80; trap = i[0];
      #2 chk($sformatf("fatal%0d", i), 1, 0, 0, 1, 1, 0, 1, 0, 3'd3);
    end
    do_reset(); idle_in();
    #2 chk("after fatal reset", 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);

    // Same-cycle commit loads the checkpoint; a commit during FLUSH overrides it.
    fault_seq("cmt in flush", 32'h2004, 3'd0, 0, 1, 32'h1000, 1, 32'h2000);
    @(negedge clk); idle_in(); cmt = 1; cpc = 32'h3000;
    #2 chk("commit clears", 0, 0, 0, 0, 0, 0, 0, 0, 3'd1);
    @(negedge clk); idle_in();
    #2 chk("retry cleared", 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    fault_seq("fault wins", 32'h3004, 3'd0, 0, 1, 32'h3000, 0, 0);

    // Reset during FLUSH: next cycle is RUN and the checkpoint is back at RESET_ADDR.
    @(negedge clk); idle_in(); fault = 1;
    #2 chk("pre-reset fault", 1, 0, 0, 1, 1, 0, 0, 0, 3'd1);
    @(negedge clk); idle_in(); reset = 1;
    @(negedge clk); reset = 0;
    #2 chk("mid-recovery reset", 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    fault_seq("replay reset addr", 32'h0, 3'd0, 0, 0, 0, 0, 0);

    // Checkpoint increment wraps modulo 2^32.
    @(negedge clk); idle_in(); cmt = 1; cpc = 32'hFFFF_FFFE;
    #2 chk("wrap commit", 0, 0, 0, 0, 0, 0, 0, 0, 3'd1);
    fault_seq("wrap replay", 32'h2, 3'd0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
